// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants,
// common to uart_rx and uart_tx.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; both flops
// reset to 1 so a reset never looks like a falling edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver with valid/ready output and overrun/framing flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the O_parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 I_baudrate_rx_clk,
  input  logic                 I_rx,
  output logic [DATA_BITS-1:0] O_rx_data,
  output logic                 O_rx_valid,
  input  logic                 I_rx_ready,
  output logic                 O_frame_err,
  output logic                 O_overrun,
  output logic [2:0]           O_dbg_state
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 O_parity_err
`endif
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  uart_state_t          r_state;
  logic [CNT_W-1:0]     r_tick_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_rx_prev;
  logic                 r_brk;
  logic                 w_rx;
  logic                 w_par_ok;
  logic                 w_complete;
  logic                 w_consume;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (I_rx),
    .o_q (w_rx)
  );

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  assign w_par_ok     = ~r_par_bad;
  assign O_parity_err = r_parity_err;
`else
  assign w_par_ok = 1'b1;
`endif

  // A frame completes at the mid-stop sample when the stop bit is high.
  assign w_complete = (r_state == ST_STOP) && !r_brk && I_baudrate_rx_clk &&
                      (r_tick_cnt == BIT_END) && w_rx && w_par_ok;
  assign w_consume  = r_valid && I_rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_brk       <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_prev   <= 1'b1;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_prev   <= w_rx;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_state    <= ST_START;
            r_tick_cnt <= '0;
            r_brk      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == MID_START) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == BIT_END) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx, r_shift[DATA_BITS-1:1]};
              if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == BIT_END) begin
              r_tick_cnt <= '0;
              r_state    <= ST_STOP;
              if ((^r_shift) != w_rx) begin
                r_parity_err <= 1'b1;
                r_par_bad    <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          // r_brk: bad stop bit seen, hold here until the line returns high.
          if (r_brk) begin
            if (w_rx) begin
              r_brk   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (I_baudrate_rx_clk) begin
            if (r_tick_cnt == BIT_END) begin
              r_tick_cnt <= '0;
              if (w_rx) begin
                r_state <= ST_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_brk       <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Single-entry output buffer: a new byte is taken only if the slot is
  // empty or being consumed on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_valid || I_rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign O_rx_data   = r_data;
  assign O_rx_valid  = r_valid;
  assign O_frame_err = r_frame_err;
  assign O_overrun   = r_overrun;
  assign O_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, hand-written overrun/glitch/break/
// reset sequences and randomized frames checked against an expected queue.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DW       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          rx;
  logic          ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic [2:0]    dbg_state;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
  logic          par_flip = 1'b0;
`endif

  uart_rx #(.DATA_BITS(DW), .OVERSAMPLE(OS)) dut (
    .clk               (clk),
    .rst               (rst),
    .I_baudrate_rx_clk (tick),
    .I_rx              (rx),
    .O_rx_data         (rx_data),
    .O_rx_valid        (rx_valid),
    .I_rx_ready        (ready),
    .O_frame_err       (frame_err),
    .O_overrun         (overrun),
    .O_dbg_state       (dbg_state)
`ifdef UART_RX_PARITY_EN
    ,
    .O_parity_err      (parity_err)
`endif
  );

  // ---------------- clock / reset / tick ----------------
  initial forever #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int ferr_cnt, ovr_cnt, perr_cnt, vhi_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    ferr_cnt = 0; ovr_cnt = 0; perr_cnt = 0; vhi_cnt = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic sb_compare(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check({name, "_data"}, got_q[i], exp_q[i]);
    exp_q.delete();
    got_q.delete();
  endtask

  // Monitor samples 1 unit after the negedge, once inputs have settled.
  logic          mon_pv = 1'b0;
  logic          mon_pc = 1'b0;
  logic [DW-1:0] mon_pd = '0;
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (mon_pv && !mon_pc && rx_valid) check("hold_stable", rx_data, mon_pd);
      if (rx_valid && ready) got_q.push_back(rx_data);
      if (rx_valid)  vhi_cnt++;
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
    end
    mon_pv = rx_valid;
    mon_pc = rx_valid && ready;
    mon_pd = rx_data;
  end

  // ---------------- drivers ----------------
  task automatic send_level(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    send_level(1'b1, n);
  endtask

  // start, DW data bits LSB first, [parity], stop_low extra low periods, stop
  task automatic send_frame(input logic [DW-1:0] d, input int stop_low);
    send_level(1'b0, BIT_CLKS);
    for (int i = 0; i < DW; i++) send_level(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
    send_level((^d) ^ par_flip, BIT_CLKS);
`endif
    if (stop_low > 0) send_level(1'b0, stop_low * BIT_CLKS);
    send_level(1'b1, BIT_CLKS);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            stop_low;
    int            par_mode;
    int            exp_bytes;
    int            exp_ferr;
    int            exp_perr;
  } vec_t;

  vec_t vecs[$];

  // ---------------- test sequence ----------------
  initial begin
    logic [DW-1:0] d;
    int            gap;
    logic          stall;

    rst = 1'b1; rx = 1'b1; ready = 1'b1;
    clear_counts();
    repeat (4) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    idle(8);

    // Directed frame table
    vecs.push_back('{8'hA5, 0, 0, 1, 0, 0});
    vecs.push_back('{8'h00, 0, 0, 1, 0, 0});
    vecs.push_back('{8'hFF, 0, 0, 1, 0, 0});
    vecs.push_back('{8'h01, 0, 0, 1, 0, 0});
    vecs.push_back('{8'h80, 0, 0, 1, 0, 0});
    vecs.push_back('{8'h33, 1, 0, 0, 1, 0});
    vecs.push_back('{8'h6E, 0, 0, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 0, 1, 0, 0, 1});
    vecs.push_back('{8'h07, 0, 0, 1, 0, 0});
`endif
    foreach (vecs[k]) begin
      clear_counts();
      if (vecs[k].exp_bytes > 0) exp_q.push_back(vecs[k].data);
`ifdef UART_RX_PARITY_EN
      par_flip = (vecs[k].par_mode != 0);
`endif
      send_frame(vecs[k].data, vecs[k].stop_low);
      idle(BIT_CLKS);
      sb_compare($sformatf("vec%0d", k));
      check($sformatf("vec%0d_ferr", k), ferr_cnt, vecs[k].exp_ferr);
      check($sformatf("vec%0d_ovr", k), ovr_cnt, 0);
      check($sformatf("vec%0d_vcycles", k), vhi_cnt, vecs[k].exp_bytes);
      check($sformatf("vec%0d_state", k), dbg_state, ST_IDLE);
`ifdef UART_RX_PARITY_EN
      check($sformatf("vec%0d_perr", k), perr_cnt, vecs[k].exp_perr);
      par_flip = 1'b0;
`endif
    end

    // Back-to-back frames while the consumer stalls
    clear_counts();
    ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 0);
    send_frame(8'hC3, 0);
    idle(BIT_CLKS);
    check("ovr_data", rx_data, 8'h3C);
    check("ovr_valid", rx_valid, 1);
    check("ovr_pulses", ovr_cnt, 1);
    ready = 1'b1;
    idle(4);
    check("ovr_drained", rx_valid, 0);
    sb_compare("overrun");

    // Short low glitch on an idle line, then a real frame
    clear_counts();
    send_level(1'b0, 2 * TICK_DIV);
    check("glitch_in_start", dbg_state, ST_START);
    send_level(1'b0, 2 * TICK_DIV);
    idle(BIT_CLKS);
    check("glitch_state", dbg_state, ST_IDLE);
    check("glitch_vcycles", vhi_cnt, 0);
    check("glitch_ferr", ferr_cnt, 0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 0);
    idle(BIT_CLKS);
    sb_compare("glitch");

    // Break: stop bit held low for 3 bit periods
    clear_counts();
    send_frame(8'h55, 3);
    idle(BIT_CLKS);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_vcycles", vhi_cnt, 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 0);
    idle(BIT_CLKS);
    check("brk_ferr_after", ferr_cnt, 1);
    sb_compare("break");

    // Reset mid-frame with a byte pending
    clear_counts();
    ready = 1'b0;
    send_frame(8'h5A, 0);
    idle(8);
    check("pre_rst_valid", rx_valid, 1);
    send_level(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_level(1'b1, BIT_CLKS);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    ready = 1'b1;
    idle(2 * BIT_CLKS);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 0);
    idle(BIT_CLKS);
    check("post_rst_ferr", ferr_cnt, 0);
    sb_compare("reset");

    // Randomized frames with random consumer stalls and gaps
    clear_counts();
    for (int n = 0; n < 16; n++) begin
      d     = DW'($urandom_range(0, 255));
      stall = 1'($urandom_range(0, 1));
      gap   = $urandom_range(0, 3 * BIT_CLKS);
      if (stall) ready = 1'b0;
      exp_q.push_back(d);
      send_frame(d, 0);
      if (stall) begin
        idle($urandom_range(1, 40));
        ready = 1'b1;
      end
      idle(gap);
    end
    idle(BIT_CLKS);
    check("rand_ovr", ovr_cnt, 0);
    check("rand_ferr", ferr_cnt, 0);
    check("rand_valid_end", rx_valid, 0);
    sb_compare("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
